// File: rtl/op2_select_stage_if.sv
`default_nettype none
// ============================================================================
// op2_select_stage_if : operand-2 stage handshake, source and bypass bundle
// Revision 1.0
// ============================================================================
interface op2_select_stage_if #(
  parameter int WIDTH = 64,
  parameter int NBYP  = 2,
  parameter int SHW   = 6,
  parameter int CNTW  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_src;
  logic [4:0]            in_rs2;
  logic [WIDTH-1:0]      in_rd2;
  logic [WIDTH-1:0]      in_imm;
  logic [SHW-1:0]        in_shamt;
  logic [WIDTH-1:0]      in_pc4;
  logic [WIDTH-1:0]      in_pcimm;
  logic [NBYP-1:0]       byp_valid;
  logic [NBYP-1:0]       byp_pending;
  logic [NBYP*5-1:0]     byp_rd;
  logic [NBYP*WIDTH-1:0] byp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_op2;
  logic [NBYP-1:0]       out_fwd;
  logic [CNTW-1:0]       stall_cnt;

  modport master (
    output in_valid, in_src, in_rs2, in_rd2, in_imm, in_shamt, in_pc4, in_pcimm,
    output byp_valid, byp_pending, byp_rd, byp_data, out_ready,
    input  in_ready, out_valid, out_op2, out_fwd, stall_cnt
  );

  modport slave (
    input  in_valid, in_src, in_rs2, in_rd2, in_imm, in_shamt, in_pc4, in_pcimm,
    input  byp_valid, byp_pending, byp_rd, byp_data, out_ready,
    output in_ready, out_valid, out_op2, out_fwd, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/op2_select_stage.sv
`default_nettype none
// ============================================================================
// op2_select_stage : execute-stage operand-2 select with bypass, hazard stall
//                    and a registered output backed by one skid entry
// Revision 1.0
// ============================================================================
module op2_select_stage #(
  parameter int WIDTH = 64,
  parameter int NBYP  = 2,
  parameter int SHW   = 6,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  op2_select_stage_if.slave bus
);

  localparam logic [2:0] SRC_IMM   = 3'd1;
  localparam logic [2:0] SRC_SHAMT = 3'd2;
  localparam logic [2:0] SRC_REG   = 3'd3;
  localparam logic [2:0] SRC_PC4   = 3'd4;
  localparam logic [2:0] SRC_PCIMM = 3'd5;

  logic             first_found;
  logic             first_pend;
  logic [NBYP-1:0]  first_oh;
  logic [WIDTH-1:0] first_data;
  logic             rs2_nz;
  logic             hazard;
  logic             hit;
  logic [WIDTH-1:0] sel_op2;
  logic [NBYP-1:0]  sel_fwd;
  logic             in_ready;
  logic             accept;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_op2_q,   out_op2_d;
  logic [NBYP-1:0]  out_fwd_q,   out_fwd_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_op2_q,  skid_op2_d;
  logic [NBYP-1:0]  skid_fwd_q,  skid_fwd_d;
  logic [CNTW-1:0]  stall_q,     stall_d;

  // Only the youngest channel naming rs2 matters: if it is pending we must
  // wait even when an older channel already has the value.
  always_comb begin
    first_found = 1'b0;
    first_pend  = 1'b0;
    first_oh    = '0;
    first_data  = '0;
    for (int k = 0; k < NBYP; k++) begin
      if (!first_found && bus.byp_valid[k] && (bus.byp_rd[5*k +: 5] == bus.in_rs2)) begin
        first_found = 1'b1;
        first_pend  = bus.byp_pending[k];
        first_oh[k] = 1'b1;
        first_data  = bus.byp_data[WIDTH*k +: WIDTH];
      end
    end
  end

  assign rs2_nz = (bus.in_rs2 != 5'd0);
  assign hazard = (bus.in_src == SRC_REG) && rs2_nz && first_found && first_pend;
  assign hit    = rs2_nz && first_found && !first_pend;

  always_comb begin
    sel_op2 = '0;
    sel_fwd = '0;
    case (bus.in_src)
      SRC_IMM:   sel_op2 = bus.in_imm;
      SRC_SHAMT: sel_op2 = WIDTH'(bus.in_shamt);
      SRC_REG: begin
        if (hit) begin
          sel_op2 = first_data;
          sel_fwd = first_oh;
        end else begin
          sel_op2 = bus.in_rd2;
        end
      end
      SRC_PC4:   sel_op2 = bus.in_pc4;
      SRC_PCIMM: sel_op2 = bus.in_pcimm;
      default:   sel_op2 = '0;
    endcase
  end

  // Skid occupancy comes from a flop so in_ready has no path from out_ready.
  assign in_ready = !skid_valid_q && !hazard;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_op2_d    = out_op2_q;
    out_fwd_d    = out_fwd_q;
    skid_valid_d = skid_valid_q;
    skid_op2_d   = skid_op2_q;
    skid_fwd_d   = skid_fwd_q;
    stall_d      = stall_q;

    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_op2_d    = skid_op2_q;
        out_fwd_d    = skid_fwd_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d  = 1'b1;
        out_op2_d    = sel_op2;
        out_fwd_d    = sel_fwd;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_op2_d   = sel_op2;
      skid_fwd_d   = sel_fwd;
    end

    if (bus.in_valid && hazard && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_op2_q    <= '0;
      out_fwd_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_op2_q   <= '0;
      skid_fwd_q   <= '0;
      stall_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_op2_q    <= out_op2_d;
      out_fwd_q    <= out_fwd_d;
      skid_valid_q <= skid_valid_d;
      skid_op2_q   <= skid_op2_d;
      skid_fwd_q   <= skid_fwd_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op2   = out_op2_q;
  assign bus.out_fwd   = out_fwd_q;
  assign bus.stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_op2_select_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_op2_select_stage : directed and randomized checks against a queue model
// Revision 1.0
// ============================================================================
module tb_op2_select_stage;

  typedef struct packed {
    logic [63:0] op2;
    logic [1:0]  fwd;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  ent_t q[$];
  int   cnt_m;

  op2_select_stage_if #(.WIDTH(64), .NBYP(2), .SHW(6), .CNTW(16)) bus ();

  op2_select_stage #(.WIDTH(64), .NBYP(2), .SHW(6), .CNTW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first channel naming rs2 decides stall; first ready channel supplies data.
  function automatic void model_sel(output logic [63:0] v, output logic [1:0] f, output logic hz);
    int first;
    int hitk;
    first = -1;
    hitk  = -1;
    v = 64'd0;
    f = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (first < 0 && bus.byp_valid[k] && bus.byp_rd[5*k +: 5] == bus.in_rs2) first = k;
      if (hitk < 0 && bus.byp_valid[k] && !bus.byp_pending[k] &&
          bus.byp_rd[5*k +: 5] == bus.in_rs2 && bus.in_rs2 != 5'd0) hitk = k;
    end
    hz = (bus.in_src == 3'd3) && (bus.in_rs2 != 5'd0) && (first >= 0) && bus.byp_pending[first];
    case (bus.in_src)
      3'd1: v = bus.in_imm;
      3'd2: v = {58'd0, bus.in_shamt};
      3'd3: begin
        if (hitk >= 0) begin
          v = bus.byp_data[64*hitk +: 64];
          f[hitk] = 1'b1;
        end else begin
          v = bus.in_rd2;
        end
      end
      3'd4: v = bus.in_pc4;
      3'd5: v = bus.in_pcimm;
      default: v = 64'd0;
    endcase
  endfunction

  task automatic tick();
    logic [63:0] v;
    logic [1:0]  f;
    logic        hz;
    bit          acc;
    bit          xf;
    ent_t        e;
    model_sel(v, f, hz);
    acc = bus.in_valid && (q.size() < 2) && !hz;
    xf  = (q.size() > 0) && bus.out_ready;
    @(posedge clk);
    if (xf) void'(q.pop_front());
    if (acc) begin
      e.op2 = v;
      e.fwd = f;
      q.push_back(e);
    end
    if (bus.in_valid && hz && cnt_m < 65535) cnt_m++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_src      = 3'd0;
    bus.in_rs2      = 5'd0;
    bus.in_rd2      = 64'd0;
    bus.in_imm      = 64'd0;
    bus.in_shamt    = 6'd0;
    bus.in_pc4      = 64'd0;
    bus.in_pcimm    = 64'd0;
    bus.byp_valid   = 2'b00;
    bus.byp_pending = 2'b00;
    bus.byp_rd      = 10'd0;
    bus.byp_data    = 128'd0;
  endtask

  task automatic rand_inputs();
    bus.in_valid    = ($urandom_range(0, 3) != 0);
    bus.in_src      = 3'($urandom_range(0, 7));
    bus.in_rs2      = 5'($urandom_range(0, 3));
    bus.in_rd2      = {$urandom, $urandom};
    bus.in_imm      = {$urandom, $urandom};
    bus.in_shamt    = 6'($urandom);
    bus.in_pc4      = {$urandom, $urandom};
    bus.in_pcimm    = {$urandom, $urandom};
    bus.byp_valid   = 2'($urandom);
    bus.byp_pending = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
    bus.byp_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    bus.byp_data    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
    end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_op2 !== 64'd0) begin failures++; $display("FAIL reset_out_op2 got=%h exp=0", bus.out_op2); end
    checks++; if (bus.out_fwd !== 2'b00) begin failures++; $display("FAIL reset_out_fwd got=%b exp=00", bus.out_fwd); end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    idle_inputs();
    reset = 1'b1;
    q.delete();
    cnt_m = 0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_sources();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_src = 3'd2; bus.in_shamt = 6'h3F; bus.in_imm = 64'hFFFF_0000_1234_5678;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op2 !== 64'h3F) begin failures++; $display("FAIL src_shamt got=%b/%h exp=1/3f", bus.out_valid, bus.out_op2); end
    bus.in_valid = 1'b1; bus.in_src = 3'd4; bus.in_pc4 = 64'h1004; bus.in_pcimm = 64'h9999;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op2 !== 64'h1004) begin failures++; $display("FAIL src_pc4 got=%b/%h exp=1/1004", bus.out_valid, bus.out_op2); end
    bus.in_valid = 1'b1; bus.in_src = 3'd7; bus.in_imm = 64'h5555;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op2 !== 64'd0) begin failures++; $display("FAIL src_reserved got=%b/%h exp=1/0", bus.out_valid, bus.out_op2); end
    bus.in_valid = 1'b1; bus.in_src = 3'd5; bus.in_pcimm = 64'hDEAD_BEEF_0000_0040;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_op2 !== 64'hDEAD_BEEF_0000_0040) begin failures++; $display("FAIL src_pcimm got=%h exp=deadbeef00000040", bus.out_op2); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL src_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_forward();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_src = 3'd3; bus.in_rs2 = 5'd5; bus.in_rd2 = 64'd1;
    bus.byp_valid = 2'b11; bus.byp_rd = {5'd5, 5'd5}; bus.byp_data = {64'hBB, 64'hAA};
    tick();
    checks++; if (bus.out_op2 !== 64'hAA || bus.out_fwd !== 2'b01) begin failures++; $display("FAIL fwd_ch0 got=%h/%b exp=aa/01", bus.out_op2, bus.out_fwd); end
    bus.in_rs2 = 5'd0; bus.byp_rd = 10'd0;
    tick();
    checks++; if (bus.out_op2 !== 64'd1 || bus.out_fwd !== 2'b00) begin failures++; $display("FAIL fwd_x0 got=%h/%b exp=1/00", bus.out_op2, bus.out_fwd); end
    bus.in_rs2 = 5'd9; bus.byp_valid = 2'b10; bus.byp_rd = {5'd9, 5'd9};
    tick();
    checks++; if (bus.out_op2 !== 64'hBB || bus.out_fwd !== 2'b10) begin failures++; $display("FAIL fwd_ch1 got=%h/%b exp=bb/10", bus.out_op2, bus.out_fwd); end
    bus.byp_valid = 2'b11; bus.byp_pending = 2'b10;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_op2 !== 64'hAA || bus.out_fwd !== 2'b01) begin failures++; $display("FAIL fwd_ignore_old_pending got=%h/%b exp=aa/01", bus.out_op2, bus.out_fwd); end
    tick();
  endtask

  task automatic test_hazard();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_src = 3'd3; bus.in_rs2 = 5'd7; bus.in_rd2 = 64'h11;
    bus.byp_valid = 2'b01; bus.byp_pending = 2'b01; bus.byp_rd = {5'd0, 5'd7}; bus.byp_data = {64'd0, 64'h44};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hazard_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      tick();
    end
    checks++; if (bus.stall_cnt !== 16'd3) begin failures++; $display("FAIL hazard_stall_cnt got=%0d exp=3", bus.stall_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hazard_no_accept got=%b exp=0", bus.out_valid); end
    bus.byp_pending = 2'b00; bus.byp_data = {64'd0, 64'h55};
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hazard_release got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_op2 !== 64'h55 || bus.out_fwd !== 2'b01) begin failures++; $display("FAIL hazard_data got=%h/%b exp=55/01", bus.out_op2, bus.out_fwd); end
    checks++; if (bus.stall_cnt !== 16'd3) begin failures++; $display("FAIL hazard_cnt_hold got=%0d exp=3", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_src = 3'd1; bus.in_imm = 64'hA0A0;
    tick();
    bus.in_imm = 64'hB0B0;
    tick();
    bus.in_valid = 1'b0; bus.in_imm = 64'hC0C0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op2 !== 64'hA0A0) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/a0a0", bus.out_valid, bus.out_op2); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op2 !== 64'hB0B0) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/b0b0", bus.out_valid, bus.out_op2); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [63:0] v;
    logic [1:0]  f;
    logic        hz;
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_sel(v, f, hz);
      checks++; if (bus.in_ready !== ((q.size() < 2) && !hz)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, (q.size() < 2) && !hz); end
      checks++; if (bus.out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (bus.out_op2 !== q[0].op2 || bus.out_fwd !== q[0].fwd) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h/%b exp=%h/%b", i, bus.out_op2, bus.out_fwd, q[0].op2, q[0].fwd); end
      end
      checks++; if (bus.stall_cnt !== 16'(cnt_m)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt, cnt_m); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_src = 3'd1; bus.in_imm = 64'h1234;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b/%b exp=0/1", bus.in_ready, bus.out_valid); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_op2 !== 64'd0 || bus.out_fwd !== 2'b00) begin failures++; $display("FAIL arst_outputs got=%b/%h/%b exp=0/0/00", bus.out_valid, bus.out_op2, bus.out_fwd); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL arst_cnt_ready got=%0d/%b exp=0/1", bus.stall_cnt, bus.in_ready); end
    q.delete();
    cnt_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_src = 3'd3; bus.in_rs2 = 5'd7;
    bus.byp_valid = 2'b01; bus.byp_pending = 2'b01; bus.byp_rd = {5'd0, 5'd7};
    repeat (65534) tick();
    checks++; if (bus.stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_near got=%h exp=fffe", bus.stall_cnt); end
    tick();
    checks++; if (bus.stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", bus.stall_cnt); end
    repeat (5) tick();
    checks++; if (bus.stall_cnt !== 16'hFFFF || 16'(cnt_m) !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.stall_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sat_no_accept got=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cnt_m    = 0;
    idle_inputs();
    bus.out_ready = 1'b1;
    test_reset();
    test_sources();
    test_forward();
    test_hazard();
    test_backpressure();
    test_random();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
